mc_ctrl_fsm: RTL and testbench
==============================

Name: mc_ctrl_fsm

Overview:
- Parametrised successor to the multicycle controller. Sequences the five-stage multicycle datapath (fetch/decode/execute/memory/writeback) through a Moore FSM.
- Adds a variable-latency memory handshake (mem_req/mem_ready) with a wait-state timeout.
- Adds an illegal-opcode/timeout trap state with a clear input, and optional performance counters.
- Drives the existing PC, IR, register file, ALU-mux and memory-mux control pins of the core top level.

Parameters:
- OPW, 6, opcode width.
- OP_RTYPE, 6'h00, R-type opcode.
- OP_ADDI, 6'h02, add-immediate opcode.
- OP_BEQ, 6'h04, branch-equal opcode.
- OP_SW, 6'h08, store-word opcode.
- OP_LW, 6'h10, load-word opcode.
- OP_J, 6'h20, jump opcode.
- TIMEOUT, 15, max consecutive mem_ready-low cycles in a memory state; 0 disables the timeout.
- CNT_W, 16, performance counter width.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- instr  in  OPW  opcode from IR[31:26]
- mem_ready  in  1  memory completes the current access this cycle
- trap_clr  in  1  leave TRAP
- mem_req  out  1  memory access pending
- PCwriteCond, PCWrite, memRead, memWrite, memToReg, ALUsrcA, RegWrite, RegDest, IRWrite, IorD  out  1 each  datapath controls
- PCSource, ALUOp, ALUsrcB  out  2 each  datapath controls
- state_out  out  4  current state encoding
- trap  out  1  FSM is in TRAP
- trap_cause  out  2  01 = illegal opcode, 10 = memory timeout, 00 = none
- retired_cnt  out  CNT_W  retired instructions
- stall_cnt  out  CNT_W  memory wait cycles

Behaviour:
- State encodings: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, RWB=8, IEXEC=9, IWB=10, BRANCH=11, JUMP=12, TRAP=15.
- Reset (reset=0):
  - state=IDLE, wait counter 0, trap_cause=00, counters 0.
  - All control outputs, mem_req and trap are 0 while in IDLE.
- IDLE -> FETCH unconditionally.
- FETCH:
  - Outputs: memRead=1, mem_req=1, IorD=0, ALUsrcA=0, ALUsrcB=01, ALUOp=00, PCSource=00.
  - IRWrite=PCWrite=mem_ready; this is the only Mealy term.
  - Stays in FETCH until mem_ready=1, then goes to DECODE.
- DECODE:
  - Outputs: ALUsrcA=0, ALUsrcB=11, ALUOp=00.
  - Next state by instr: LW/SW -> MEMADR, RTYPE -> EXEC, ADDI -> IEXEC, BEQ -> BRANCH, J -> JUMP.
  - Any other opcode -> TRAP with cause 01.
- MEMADR: ALUsrcA=1, ALUsrcB=10, ALUOp=00. Goes to MEMRD on LW, MEMWR on SW.
- MEMRD: memRead=1, mem_req=1, IorD=1. Holds until mem_ready, then MEMWB.
- MEMWB: RegWrite=1, memToReg=1, RegDest=0. Then FETCH.
- MEMWR: memWrite=1, mem_req=1, IorD=1. Holds until mem_ready, then FETCH.
- EXEC: ALUsrcA=1, ALUsrcB=00, ALUOp=10. Then RWB.
- RWB: RegWrite=1, RegDest=1, memToReg=0. Then FETCH.
- IEXEC: ALUsrcA=1, ALUsrcB=10, ALUOp=00. Then IWB.
- IWB: RegWrite=1, RegDest=0, memToReg=0. Then FETCH.
- BRANCH: ALUsrcA=1, ALUsrcB=00, ALUOp=01, PCwriteCond=1, PCSource=01. Then FETCH.
- JUMP: PCWrite=1, PCSource=10. Then FETCH.
- All outputs not listed for a state are 0.
- Wait counter:
  - Cleared on entry to FETCH, MEMRD or MEMWR.
  - Increments each cycle in those states while mem_ready=0.
  - If mem_ready=0 while count==TIMEOUT (TIMEOUT>0), next state is TRAP with cause 10. The timeout therefore fires on the (TIMEOUT+1)th consecutive low cycle.
  - If mem_ready=1 on the same cycle the count reaches TIMEOUT, ready wins and no trap is taken.
- TRAP:
  - All controls and mem_req are 0; trap=1; trap_cause holds its value.
  - trap_clr=1 -> IDLE and trap_cause=00.
  - trap_clr is ignored outside TRAP.
- Reset asserted in any state, including mid-wait, returns to IDLE immediately and asynchronously.

Optional Feature:
- Macro: MC_PERF_CNT_EN.
- Defined:
  - retired_cnt increments on exit from MEMWB, MEMWR, RWB, IWB, BRANCH and JUMP.
  - stall_cnt increments each cycle mem_req=1 and mem_ready=0.
  - Both counters wrap modulo 2^CNT_W, are cleared by reset, and are not cleared by trap_clr.
- Undefined: retired_cnt and stall_cnt are tied to 0 and no counter flops exist.

Test Plan:
- Release reset, mem_ready held 1, instr=6'h00: state_out sequence 0,1,2,7,8,1. IRWrite=1 for one cycle in state 1; RegWrite=1 and RegDest=1 in state 8.
- instr=6'h10 (LW), mem_ready low for 3 cycles in MEMRD: MEMRD lasts 4 cycles with mem_req=1 and IorD=1, then MEMWB with memToReg=1. With MC_PERF_CNT_EN, stall_cnt=3 and retired_cnt=1.
- instr=6'h04 (BEQ): BRANCH asserts PCwriteCond=1, PCSource=01, ALUOp=01 for exactly 1 cycle. instr=6'h20 (J): PCWrite=1, PCSource=10.
- instr=6'h3F: DECODE -> TRAP, trap=1, trap_cause=01, all controls 0. trap_clr pulse -> IDLE then FETCH, trap_cause=00.
- TIMEOUT=15, mem_ready=0 forever in FETCH: TRAP entered after 16 wait cycles with cause 10. Repeat with mem_ready=1 on the 16th cycle: no trap, DECODE follows.
- Assert reset during MEMWR wait: state_out=0 immediately and memWrite=0 without waiting for clk. Counters clear to 0.

Source files
------------

// File: rtl/mc_ctrl_fsm_if.sv
// Control bundle between the multicycle sequencer (master) and the core datapath (slave).
// Pin names match the existing core top level so the datapath wiring is unchanged.
interface mc_ctrl_fsm_if #(
  parameter int OPW   = 6,
  parameter int CNT_W = 16
);
  logic [OPW-1:0]   instr;
  logic             mem_ready;
  logic             trap_clr;
  logic             mem_req;
  logic             PCwriteCond;
  logic             PCWrite;
  logic             memRead;
  logic             memWrite;
  logic             memToReg;
  logic             ALUsrcA;
  logic             RegWrite;
  logic             RegDest;
  logic             IRWrite;
  logic             IorD;
  logic [1:0]       PCSource;
  logic [1:0]       ALUOp;
  logic [1:0]       ALUsrcB;
  logic [3:0]       state_out;
  logic             trap;
  logic [1:0]       trap_cause;
  logic [CNT_W-1:0] retired_cnt;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    input  instr, mem_ready, trap_clr,
    output mem_req, PCwriteCond, PCWrite, memRead, memWrite, memToReg, ALUsrcA,
           RegWrite, RegDest, IRWrite, IorD, PCSource, ALUOp, ALUsrcB,
           state_out, trap, trap_cause, retired_cnt, stall_cnt
  );

  modport slave (
    output instr, mem_ready, trap_clr,
    input  mem_req, PCwriteCond, PCWrite, memRead, memWrite, memToReg, ALUsrcA,
           RegWrite, RegDest, IRWrite, IorD, PCSource, ALUOp, ALUsrcB,
           state_out, trap, trap_cause, retired_cnt, stall_cnt
  );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Moore sequencer for the 5-stage multicycle datapath; controls registered, except IRWrite/PCWrite follow mem_ready in FETCH.
// Waits in FETCH/MEMRD/MEMWR for mem_ready and traps after TIMEOUT; define MC_PERF_CNT_EN to add retired/stall counters.
module mc_ctrl_fsm #(
  parameter int             OPW      = 6,
  parameter logic [OPW-1:0] OP_RTYPE = 'h00,
  parameter logic [OPW-1:0] OP_ADDI  = 'h02,
  parameter logic [OPW-1:0] OP_BEQ   = 'h04,
  parameter logic [OPW-1:0] OP_SW    = 'h08,
  parameter logic [OPW-1:0] OP_LW    = 'h10,
  parameter logic [OPW-1:0] OP_J     = 'h20,
  parameter int             TIMEOUT  = 15,
  parameter int             CNT_W    = 16
) (
  input  logic          clk,
  input  logic          reset,
  mc_ctrl_fsm_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_RWB    = 4'd8,
    S_IEXEC  = 4'd9,
    S_IWB    = 4'd10,
    S_BRANCH = 4'd11,
    S_JUMP   = 4'd12,
    S_TRAP   = 4'd15
  } state_t;

  typedef struct packed {
    logic       pc_write_cond;
    logic       pc_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic       reg_write;
    logic       reg_dest;
    logic       iord;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic [1:0] alu_src_b;
    logic       mem_req;
    logic       trap;
  } ctrl_t;

  localparam bit                TO_EN  = (TIMEOUT > 0);
  localparam int                WAIT_W = TO_EN ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] TO_V   = WAIT_W'(TIMEOUT);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [1:0]        cause_q, cause_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic              fetch_rdy;

  // Moore decode applied to the next state so every control leaves a flop.
  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:  begin c.mem_read = 1'b1; c.mem_req = 1'b1; c.alu_src_b = 2'b01; end
      S_DECODE: c.alu_src_b = 2'b11;
      S_MEMADR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_MEMRD:  begin c.mem_read = 1'b1; c.mem_req = 1'b1; c.iord = 1'b1; end
      S_MEMWB:  begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      S_MEMWR:  begin c.mem_write = 1'b1; c.mem_req = 1'b1; c.iord = 1'b1; end
      S_EXEC:   begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
      S_RWB:    begin c.reg_write = 1'b1; c.reg_dest = 1'b1; end
      S_IEXEC:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_IWB:    c.reg_write = 1'b1;
      S_BRANCH: begin
        c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_write_cond = 1'b1; c.pc_source = 2'b01;
      end
      S_JUMP:   begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
      S_TRAP:   c.trap = 1'b1;
      default:  c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    cause_d = cause_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.instr)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_ADDI:      state_d = S_IEXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default: begin state_d = S_TRAP; cause_d = 2'b01; end
        endcase
      end
      S_MEMADR: begin
        // Opcode can only have changed under a misbehaving IR; treat as illegal.
        if (bus.instr == OP_LW)      state_d = S_MEMRD;
        else if (bus.instr == OP_SW) state_d = S_MEMWR;
        else begin state_d = S_TRAP; cause_d = 2'b01; end
      end
      S_MEMRD:  if (bus.mem_ready) state_d = S_MEMWB;
      S_MEMWR:  if (bus.mem_ready) state_d = S_FETCH;
      S_MEMWB, S_RWB, S_IWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_EXEC:   state_d = S_RWB;
      S_IEXEC:  state_d = S_IWB;
      S_TRAP:   if (bus.trap_clr) begin state_d = S_IDLE; cause_d = 2'b00; end
      default:  state_d = S_IDLE;
    endcase

    // Ready on the limit cycle wins: the trap only fires while still waiting.
    if ((state_q == S_FETCH || state_q == S_MEMRD || state_q == S_MEMWR) && !bus.mem_ready) begin
      if (TO_EN && wait_q == TO_V) begin
        state_d = S_TRAP;
        cause_d = 2'b10;
      end else begin
        wait_d = wait_q + 1'b1;
      end
    end

    if ((state_d == S_FETCH || state_d == S_MEMRD || state_d == S_MEMWR) && state_d != state_q)
      wait_d = '0;

    ctrl_d = decode_ctrl(state_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      cause_q <= 2'b00;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cause_q <= cause_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign fetch_rdy       = (state_q == S_FETCH) && bus.mem_ready;

  assign bus.mem_req     = ctrl_q.mem_req;
  assign bus.PCwriteCond = ctrl_q.pc_write_cond;
  assign bus.PCWrite     = ctrl_q.pc_write | fetch_rdy;
  assign bus.IRWrite     = fetch_rdy;
  assign bus.memRead     = ctrl_q.mem_read;
  assign bus.memWrite    = ctrl_q.mem_write;
  assign bus.memToReg    = ctrl_q.mem_to_reg;
  assign bus.ALUsrcA     = ctrl_q.alu_src_a;
  assign bus.RegWrite    = ctrl_q.reg_write;
  assign bus.RegDest     = ctrl_q.reg_dest;
  assign bus.IorD        = ctrl_q.iord;
  assign bus.PCSource    = ctrl_q.pc_source;
  assign bus.ALUOp       = ctrl_q.alu_op;
  assign bus.ALUsrcB     = ctrl_q.alu_src_b;
  assign bus.state_out   = state_q;
  assign bus.trap        = ctrl_q.trap;
  assign bus.trap_cause  = cause_q;

`ifdef MC_PERF_CNT_EN
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  always_comb begin
    retired_d = retired_q;
    stall_d   = stall_q;
    // Retirement is the hand-back to FETCH; a store that times out never retires.
    if ((state_q == S_MEMWB || state_q == S_MEMWR || state_q == S_RWB || state_q == S_IWB ||
         state_q == S_BRANCH || state_q == S_JUMP) && state_d == S_FETCH)
      retired_d = retired_q + 1'b1;
    if (ctrl_q.mem_req && !bus.mem_ready)
      stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      retired_q <= retired_d;
      stall_q   <= stall_d;
    end
  end

  assign bus.retired_cnt = retired_q;
  assign bus.stall_cnt   = stall_q;
`else
  assign bus.retired_cnt = {CNT_W{1'b0}};
  assign bus.stall_cnt   = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: state sequences, control vectors, trap/timeout paths and async reset.
module tb_mc_ctrl_fsm;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;

`ifdef MC_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {PCwriteCond,PCWrite,memRead,memWrite,memToReg,ALUsrcA,RegWrite,RegDest,IRWrite,IorD,
  //  PCSource[2],ALUOp[2],ALUsrcB[2],mem_req,trap}
  localparam logic [17:0] E_ZERO  = 18'b0;
  localparam logic [17:0] E_FR    = {1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b01,1'b1,1'b0};
  localparam logic [17:0] E_FW    = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b01,1'b1,1'b0};
  localparam logic [17:0] E_DEC   = {10'b0,2'b00,2'b00,2'b11,2'b00};
  localparam logic [17:0] E_MADR  = {5'b0,1'b1,4'b0,2'b00,2'b00,2'b10,2'b00};
  localparam logic [17:0] E_MRD   = {2'b00,1'b1,7'b0000001,6'b0,1'b1,1'b0};
  localparam logic [17:0] E_MWB   = {4'b0,1'b1,1'b0,1'b1,3'b0,6'b0,2'b00};
  localparam logic [17:0] E_MWR   = {3'b000,1'b1,6'b000001,6'b0,1'b1,1'b0};
  localparam logic [17:0] E_EXEC  = {5'b0,1'b1,4'b0,2'b00,2'b10,2'b00,2'b00};
  localparam logic [17:0] E_RWB   = {6'b0,1'b1,1'b1,2'b0,6'b0,2'b00};
  localparam logic [17:0] E_IEXEC = {5'b0,1'b1,4'b0,2'b00,2'b00,2'b10,2'b00};
  localparam logic [17:0] E_IWB   = {6'b0,1'b1,3'b0,6'b0,2'b00};
  localparam logic [17:0] E_BR    = {1'b1,4'b0,1'b1,4'b0,2'b01,2'b01,2'b00,2'b00};
  localparam logic [17:0] E_JMP   = {1'b0,1'b1,8'b0,2'b10,2'b00,2'b00,2'b00};
  localparam logic [17:0] E_TRAP  = {17'b0,1'b1};

  typedef struct packed {
    logic [5:0]  instr;
    logic        rdy;
    logic        clr;
    logic [3:0]  st;
    logic [17:0] ctrl;
    logic [1:0]  cause;
  } vec_t;

  mc_ctrl_fsm_if #(.OPW(6), .CNT_W(16)) bus ();

  mc_ctrl_fsm #(.TIMEOUT(15), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] ctrl_now();
    return {bus.PCwriteCond, bus.PCWrite, bus.memRead, bus.memWrite, bus.memToReg, bus.ALUsrcA,
            bus.RegWrite, bus.RegDest, bus.IRWrite, bus.IorD, bus.PCSource, bus.ALUOp,
            bus.ALUsrcB, bus.mem_req, bus.trap};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.instr = 6'h00;
    bus.mem_ready = 1'b1;
    bus.trap_clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.instr = 6'h00;
    bus.mem_ready = 1'b1;
    bus.trap_clr = 1'b0;
    #1;
    total++; if (bus.state_out !== 4'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", bus.state_out); end
    total++; if (ctrl_now() !== E_ZERO) begin bad++; $display("FAIL reset_ctrl got=%h exp=%h", ctrl_now(), E_ZERO); end
    total++; if (bus.trap_cause !== 2'b00) begin bad++; $display("FAIL reset_cause got=%b exp=00", bus.trap_cause); end
    total++; if (bus.retired_cnt !== 16'd0 || bus.stall_cnt !== 16'd0) begin
      bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", bus.retired_cnt, bus.stall_cnt);
    end
  endtask

  task automatic test_rtype();
    vec_t tv [6];
    tv = '{ {6'h00,1'b1,1'b0,4'd0,E_ZERO,2'b00}, {6'h00,1'b1,1'b0,4'd1,E_FR,2'b00},
            {6'h00,1'b1,1'b0,4'd2,E_DEC,2'b00},  {6'h00,1'b1,1'b0,4'd7,E_EXEC,2'b00},
            {6'h00,1'b1,1'b0,4'd8,E_RWB,2'b00},  {6'h00,1'b1,1'b0,4'd1,E_FR,2'b00} };
    do_reset();
    for (int i = 0; i < 6; i++) begin
      bus.instr = tv[i].instr; bus.mem_ready = tv[i].rdy; bus.trap_clr = tv[i].clr; #1;
      total++; if (bus.state_out !== tv[i].st) begin bad++; $display("FAIL rtype[%0d] state got=%0d exp=%0d", i, bus.state_out, tv[i].st); end
      total++; if (ctrl_now() !== tv[i].ctrl) begin bad++; $display("FAIL rtype[%0d] ctrl got=%h exp=%h", i, ctrl_now(), tv[i].ctrl); end
      total++; if (bus.trap_cause !== tv[i].cause) begin bad++; $display("FAIL rtype[%0d] cause got=%b exp=%b", i, bus.trap_cause, tv[i].cause); end
      if (i < 5) step();
    end
    total++; if (bus.retired_cnt !== (PERF ? 16'd1 : 16'd0)) begin bad++; $display("FAIL rtype retired got=%0d", bus.retired_cnt); end
  endtask

  task automatic test_lw();
    vec_t tv [10];
    tv = '{ {6'h10,1'b1,1'b0,4'd0,E_ZERO,2'b00}, {6'h10,1'b1,1'b0,4'd1,E_FR,2'b00},
            {6'h10,1'b1,1'b0,4'd2,E_DEC,2'b00},  {6'h10,1'b0,1'b0,4'd3,E_MADR,2'b00},
            {6'h10,1'b0,1'b0,4'd4,E_MRD,2'b00},  {6'h10,1'b0,1'b0,4'd4,E_MRD,2'b00},
            {6'h10,1'b0,1'b0,4'd4,E_MRD,2'b00},  {6'h10,1'b1,1'b0,4'd4,E_MRD,2'b00},
            {6'h10,1'b1,1'b0,4'd5,E_MWB,2'b00},  {6'h10,1'b1,1'b0,4'd1,E_FR,2'b00} };
    do_reset();
    for (int i = 0; i < 10; i++) begin
      bus.instr = tv[i].instr; bus.mem_ready = tv[i].rdy; bus.trap_clr = tv[i].clr; #1;
      total++; if (bus.state_out !== tv[i].st) begin bad++; $display("FAIL lw[%0d] state got=%0d exp=%0d", i, bus.state_out, tv[i].st); end
      total++; if (ctrl_now() !== tv[i].ctrl) begin bad++; $display("FAIL lw[%0d] ctrl got=%h exp=%h", i, ctrl_now(), tv[i].ctrl); end
      if (i < 9) step();
    end
    total++; if (bus.stall_cnt !== (PERF ? 16'd3 : 16'd0)) begin bad++; $display("FAIL lw stall got=%0d", bus.stall_cnt); end
    total++; if (bus.retired_cnt !== (PERF ? 16'd1 : 16'd0)) begin bad++; $display("FAIL lw retired got=%0d", bus.retired_cnt); end
  endtask

  task automatic test_branch_jump_addi();
    vec_t tv [12];
    tv = '{ {6'h04,1'b1,1'b0,4'd0,E_ZERO,2'b00}, {6'h04,1'b1,1'b0,4'd1,E_FR,2'b00},
            {6'h04,1'b1,1'b0,4'd2,E_DEC,2'b00},  {6'h04,1'b1,1'b0,4'd11,E_BR,2'b00},
            {6'h20,1'b1,1'b0,4'd1,E_FR,2'b00},   {6'h20,1'b1,1'b0,4'd2,E_DEC,2'b00},
            {6'h20,1'b1,1'b0,4'd12,E_JMP,2'b00}, {6'h02,1'b1,1'b0,4'd1,E_FR,2'b00},
            {6'h02,1'b1,1'b0,4'd2,E_DEC,2'b00},  {6'h02,1'b1,1'b0,4'd9,E_IEXEC,2'b00},
            {6'h02,1'b1,1'b0,4'd10,E_IWB,2'b00}, {6'h02,1'b1,1'b0,4'd1,E_FR,2'b00} };
    do_reset();
    for (int i = 0; i < 12; i++) begin
      bus.instr = tv[i].instr; bus.mem_ready = tv[i].rdy; bus.trap_clr = tv[i].clr; #1;
      total++; if (bus.state_out !== tv[i].st) begin bad++; $display("FAIL brj[%0d] state got=%0d exp=%0d", i, bus.state_out, tv[i].st); end
      total++; if (ctrl_now() !== tv[i].ctrl) begin bad++; $display("FAIL brj[%0d] ctrl got=%h exp=%h", i, ctrl_now(), tv[i].ctrl); end
      if (i < 11) step();
    end
    total++; if (bus.retired_cnt !== (PERF ? 16'd3 : 16'd0)) begin bad++; $display("FAIL brj retired got=%0d", bus.retired_cnt); end
  endtask

  task automatic test_illegal();
    vec_t tv [8];
    // trap_clr pulses in FETCH must be ignored.
    tv = '{ {6'h3F,1'b1,1'b0,4'd0,E_ZERO,2'b00}, {6'h3F,1'b1,1'b1,4'd1,E_FR,2'b00},
            {6'h3F,1'b1,1'b0,4'd2,E_DEC,2'b00},  {6'h3F,1'b1,1'b0,4'd15,E_TRAP,2'b01},
            {6'h3F,1'b1,1'b0,4'd15,E_TRAP,2'b01},{6'h3F,1'b1,1'b1,4'd15,E_TRAP,2'b01},
            {6'h00,1'b1,1'b0,4'd0,E_ZERO,2'b00}, {6'h00,1'b1,1'b0,4'd1,E_FR,2'b00} };
    do_reset();
    for (int i = 0; i < 8; i++) begin
      bus.instr = tv[i].instr; bus.mem_ready = tv[i].rdy; bus.trap_clr = tv[i].clr; #1;
      total++; if (bus.state_out !== tv[i].st) begin bad++; $display("FAIL illegal[%0d] state got=%0d exp=%0d", i, bus.state_out, tv[i].st); end
      total++; if (ctrl_now() !== tv[i].ctrl) begin bad++; $display("FAIL illegal[%0d] ctrl got=%h exp=%h", i, ctrl_now(), tv[i].ctrl); end
      total++; if (bus.trap_cause !== tv[i].cause) begin bad++; $display("FAIL illegal[%0d] cause got=%b exp=%b", i, bus.trap_cause, tv[i].cause); end
      if (i < 7) step();
    end
    bus.trap_clr = 1'b0;
    total++; if (bus.retired_cnt !== 16'd0) begin bad++; $display("FAIL illegal retired got=%0d exp=0", bus.retired_cnt); end
  endtask

  task automatic test_timeout();
    do_reset();
    bus.instr = 6'h00; bus.mem_ready = 1'b0; #1;
    total++; if (bus.state_out !== 4'd0) begin bad++; $display("FAIL to_idle state got=%0d exp=0", bus.state_out); end
    step();
    for (int i = 0; i < 16; i++) begin
      #1;
      total++; if (bus.state_out !== 4'd1 || ctrl_now() !== E_FW) begin
        bad++; $display("FAIL to_wait[%0d] state=%0d ctrl=%h exp=1/%h", i, bus.state_out, ctrl_now(), E_FW);
      end
      step();
    end
    #1;
    total++; if (bus.state_out !== 4'd15) begin bad++; $display("FAIL to_trap state got=%0d exp=15", bus.state_out); end
    total++; if (bus.trap_cause !== 2'b10) begin bad++; $display("FAIL to_trap cause got=%b exp=10", bus.trap_cause); end
    total++; if (ctrl_now() !== E_TRAP) begin bad++; $display("FAIL to_trap ctrl got=%h exp=%h", ctrl_now(), E_TRAP); end
    total++; if (bus.stall_cnt !== (PERF ? 16'd16 : 16'd0)) begin bad++; $display("FAIL to_trap stall got=%0d", bus.stall_cnt); end
    bus.trap_clr = 1'b1;
    step();
    bus.trap_clr = 1'b0; #1;
    total++; if (bus.state_out !== 4'd0 || bus.trap_cause !== 2'b00) begin
      bad++; $display("FAIL to_clr state=%0d cause=%b exp=0/00", bus.state_out, bus.trap_cause);
    end
    step();
    for (int i = 0; i < 15; i++) begin
      #1;
      total++; if (bus.state_out !== 4'd1) begin bad++; $display("FAIL to_rewait[%0d] state got=%0d exp=1", i, bus.state_out); end
      step();
    end
    bus.mem_ready = 1'b1; #1;
    total++; if (bus.state_out !== 4'd1 || ctrl_now() !== E_FR) begin
      bad++; $display("FAIL to_edge state=%0d ctrl=%h exp=1/%h", bus.state_out, ctrl_now(), E_FR);
    end
    step(); #1;
    total++; if (bus.state_out !== 4'd2) begin bad++; $display("FAIL to_edge_next state got=%0d exp=2", bus.state_out); end
    total++; if (bus.stall_cnt !== (PERF ? 16'd31 : 16'd0)) begin bad++; $display("FAIL to_edge stall got=%0d", bus.stall_cnt); end
  endtask

  task automatic test_reset_mid_wait();
    vec_t tv [6];
    tv = '{ {6'h08,1'b1,1'b0,4'd0,E_ZERO,2'b00}, {6'h08,1'b1,1'b0,4'd1,E_FR,2'b00},
            {6'h08,1'b1,1'b0,4'd2,E_DEC,2'b00},  {6'h08,1'b0,1'b0,4'd3,E_MADR,2'b00},
            {6'h08,1'b0,1'b0,4'd6,E_MWR,2'b00},  {6'h08,1'b0,1'b0,4'd6,E_MWR,2'b00} };
    do_reset();
    for (int i = 0; i < 6; i++) begin
      bus.instr = tv[i].instr; bus.mem_ready = tv[i].rdy; bus.trap_clr = tv[i].clr; #1;
      total++; if (bus.state_out !== tv[i].st) begin bad++; $display("FAIL sw[%0d] state got=%0d exp=%0d", i, bus.state_out, tv[i].st); end
      total++; if (ctrl_now() !== tv[i].ctrl) begin bad++; $display("FAIL sw[%0d] ctrl got=%h exp=%h", i, ctrl_now(), tv[i].ctrl); end
      step();
    end
    total++; if (bus.state_out !== 4'd6 || bus.stall_cnt !== (PERF ? 16'd2 : 16'd0)) begin
      bad++; $display("FAIL sw_wait state=%0d stall=%0d", bus.state_out, bus.stall_cnt);
    end
    #2 reset = 1'b0;
    #1;
    total++; if (bus.state_out !== 4'd0) begin bad++; $display("FAIL async_rst state got=%0d exp=0", bus.state_out); end
    total++; if (bus.memWrite !== 1'b0 || bus.mem_req !== 1'b0) begin
      bad++; $display("FAIL async_rst memWrite=%b mem_req=%b exp=0/0", bus.memWrite, bus.mem_req);
    end
    total++; if (bus.retired_cnt !== 16'd0 || bus.stall_cnt !== 16'd0) begin
      bad++; $display("FAIL async_rst cnt got=%0d/%0d exp=0/0", bus.retired_cnt, bus.stall_cnt);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    @(negedge clk);
    test_rtype();
    test_lw();
    test_branch_jump_addi();
    test_illegal();
    test_timeout();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
